periferico_rx: RTL and testbench

- Receive-side endpoint of the CPU's 4-bit send/ack output channel.
- Completes a 4-phase handshake per word driven on cpu_send / cpu_dados.
- Buffers accepted words in a small show-ahead FIFO read by local logic.
- Withholds ack while the FIFO is full, so the CPU transmitter stalls instead of losing data.

---
 rtl/periferico_rx.sv | 144 ++++++++++++++
 tb/tb_periferico_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/periferico_rx.sv
// Receive endpoint of the CPU 4-bit send/ack channel: 4-phase handshake into a show-ahead FIFO.
// Optional 2-flop request synchronizer enabled by defining PERIFERICO_RX_SYNC_EN.
module periferico_rx #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              per_clk,
  input  logic              per_rst,
  input  logic              per_send,
  input  logic [DATA_W-1:0] per_dados,
  output logic              per_ack,
  input  logic              per_rd,
  output logic [DATA_W-1:0] per_rd_dados,
  output logic              per_empty,
  output logic              per_full,
  output logic [CNT_W-1:0]  per_count,
  output logic [7:0]        per_total
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_LOW = 1'b1;

  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic              ack_r;
  logic              ack_nxt_s;
  logic              send_s;
  logic              wr_s;
  logic              rd_s;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [7:0]        total_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

`ifdef PERIFERICO_RX_SYNC_EN
  logic [1:0] sync_r;

  // Two-flop synchronizer for the request line; data needs none since it is stable while send is high.
  always_ff @(posedge per_clk or posedge per_rst) begin
    if (per_rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], per_send};
    end
  end

  assign send_s = sync_r[1];
`else
  assign send_s = per_send;
`endif

  assign per_ack      = ack_r;
  assign per_count    = count_r;
  assign per_total    = total_r;
  assign per_full     = (count_r == CNT_W'(DEPTH));
  assign per_empty    = (count_r == {CNT_W{1'b0}});
  assign per_rd_dados = mem_r[rd_ptr_r];

  // Handshake FSM next state; a full FIFO simply keeps us in IDLE so the sender stalls.
  always_comb begin
    state_nxt_s = state_r;
    ack_nxt_s   = ack_r;
    wr_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (send_s && !per_full) begin
          wr_s        = 1'b1;
          ack_nxt_s   = 1'b1;
          state_nxt_s = ST_WAIT_LOW;
        end else begin
          ack_nxt_s   = 1'b0;
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_LOW: begin
        if (!send_s) begin
          ack_nxt_s   = 1'b0;
          state_nxt_s = ST_IDLE;
        end else begin
          ack_nxt_s   = 1'b1;
          state_nxt_s = ST_WAIT_LOW;
        end
      end
      default: begin
        ack_nxt_s   = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Pops are judged on the pre-edge count, so a read of an empty FIFO is dropped even if a write lands.
  always_comb begin
    if (per_rd && !per_empty) begin
      rd_s = 1'b1;
    end else begin
      rd_s = 1'b0;
    end
  end

  // Handshake state, ack and accepted-word counter.
  always_ff @(posedge per_clk or posedge per_rst) begin
    if (per_rst) begin
      state_r <= ST_IDLE;
      ack_r   <= 1'b0;
      total_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      ack_r   <= ack_nxt_s;
      if (wr_s) begin
        total_r <= total_r + 8'd1;
      end
    end
  end

  // FIFO storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge per_clk or posedge per_rst) begin
    if (per_rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= per_dados;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_periferico_rx.sv
// Self-checking bench for periferico_rx: directed scenarios with literal expectations plus
// randomized handshakes/pops compared every cycle against a queue-based model.
module tb_periferico_rx;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
`ifdef PERIFERICO_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic              per_clk = 1'b0;
  logic              per_rst = 1'b1;
  logic              per_send = 1'b0;
  logic [DATA_W-1:0] per_dados = 4'h0;
  logic              per_ack;
  logic              per_rd = 1'b0;
  logic [DATA_W-1:0] per_rd_dados;
  logic              per_empty;
  logic              per_full;
  logic [CNT_W-1:0]  per_count;
  logic [7:0]        per_total;

  int n_tests = 0;
  int n_fail  = 0;

  periferico_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .per_clk(per_clk), .per_rst(per_rst), .per_send(per_send), .per_dados(per_dados),
    .per_ack(per_ack), .per_rd(per_rd), .per_rd_dados(per_rd_dados), .per_empty(per_empty),
    .per_full(per_full), .per_count(per_count), .per_total(per_total)
  );

  always #5 per_clk = ~per_clk;

  // Behavioural model: a word queue, an ack flag and a total, updated from pre-edge inputs.
  logic [DATA_W-1:0] m_q[$];
  bit                m_ack;
  logic [7:0]        m_total;
  bit [1:0]          m_hist;
  bit                m_seen, m_acc, m_pop;

  always @(posedge per_clk or posedge per_rst) begin
    if (per_rst) begin
      m_q.delete();
      m_ack   = 1'b0;
      m_total = 8'd0;
      m_hist  = 2'b00;
    end else begin
      m_seen = (LAT == 0) ? per_send : m_hist[1];
      m_hist = {m_hist[0], per_send};
      m_acc  = !m_ack && m_seen && (m_q.size() < DEPTH);
      m_pop  = per_rd && (m_q.size() != 0);
      if (m_pop) void'(m_q.pop_front());
      if (m_acc) begin
        m_q.push_back(per_dados);
        m_total = m_total + 8'd1;
        m_ack   = 1'b1;
      end else if (m_ack && !m_seen) begin
        m_ack = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge per_clk) begin
    if (!per_rst) begin
      chk("ack", 32'(per_ack), 32'(m_ack));
      chk("count", 32'(per_count), 32'(m_q.size()));
      chk("empty", 32'(per_empty), 32'(m_q.size() == 0));
      chk("full", 32'(per_full), 32'(m_q.size() == DEPTH));
      chk("total", 32'(per_total), 32'(m_total));
      if (m_q.size() != 0) chk("head", 32'(per_rd_dados), 32'(m_q[0]));
    end
  end

  task automatic tick();
    @(posedge per_clk);
    #2;
  endtask

  task automatic wait_ack(input logic val, input string nm);
    int k;
    k = 0;
    while (per_ack !== val && k < 40) begin
      tick();
      k++;
    end
    chk(nm, 32'(per_ack), 32'(val));
  endtask

  task automatic do_reset();
    per_rst  = 1'b1;
    per_send = 1'b0;
    per_rd   = 1'b0;
    tick();
    per_rst = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d);
    per_dados = d;
    per_send  = 1'b1;
    wait_ack(1'b1, "hs_ack_rise");
    per_send = 1'b0;
    wait_ack(1'b0, "hs_ack_fall");
  endtask

  task automatic pop();
    per_rd = 1'b1;
    tick();
    per_rd = 1'b0;
  endtask

  logic [DATA_W-1:0] drain_exp [4];

  initial begin
    // Reset held with send asserted.
    per_rst   = 1'b1;
    per_send  = 1'b1;
    per_dados = 4'h5;
    repeat (5) tick();
    chk("rst_ack", 32'(per_ack), 32'd0);
    chk("rst_empty", 32'(per_empty), 32'd1);
    chk("rst_count", 32'(per_count), 32'd0);
    chk("rst_total", 32'(per_total), 32'd0);
    chk("rst_head", 32'(per_rd_dados), 32'd0);
    per_rst = 1'b0;
    repeat (LAT) tick();
    chk("rel_ack_early", 32'(per_ack), 32'd0);
    tick();
    chk("rel_ack", 32'(per_ack), 32'd1);
    chk("rel_head", 32'(per_rd_dados), 32'h5);
    per_send = 1'b0;
    repeat (LAT) tick();
    chk("drop_ack_hold", 32'(per_ack), 32'd1);
    tick();
    chk("drop_ack", 32'(per_ack), 32'd0);

    // Single transfer.
    do_reset();
    send_word(4'hA);
    chk("single_head", 32'(per_rd_dados), 32'hA);
    chk("single_count", 32'(per_count), 32'd1);
    chk("single_total", 32'(per_total), 32'd1);

    // Long send: one write only.
    do_reset();
    per_dados = 4'h3;
    per_send  = 1'b1;
    repeat (10) tick();
    chk("long_ack", 32'(per_ack), 32'd1);
    per_send = 1'b0;
    wait_ack(1'b0, "long_fall");
    chk("long_count", 32'(per_count), 32'd1);
    chk("long_total", 32'(per_total), 32'd1);

    // Backpressure on a full FIFO.
    do_reset();
    send_word(4'h5); send_word(4'h6); send_word(4'h7); send_word(4'h8);
    chk("bp_full", 32'(per_full), 32'd1);
    per_dados = 4'h9;
    per_send  = 1'b1;
    repeat (LAT + 3) tick();
    chk("bp_stall", 32'(per_ack), 32'd0);
    pop();
    chk("bp_after_pop_ack", 32'(per_ack), 32'd0);
    chk("bp_after_pop_count", 32'(per_count), 32'd3);
    tick();
    chk("bp_accept", 32'(per_ack), 32'd1);
    chk("bp_count4", 32'(per_count), 32'd4);
    per_send = 1'b0;
    wait_ack(1'b0, "bp_fall");
    drain_exp[0] = 4'h6; drain_exp[1] = 4'h7; drain_exp[2] = 4'h8; drain_exp[3] = 4'h9;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain", 32'(per_rd_dados), 32'(drain_exp[i]));
      pop();
    end
    chk("bp_empty", 32'(per_empty), 32'd1);

    // Write and pop on the same edge, then pop of an empty FIFO.
    do_reset();
    send_word(4'h1); send_word(4'h2);
    per_dados = 4'h3;
    per_send  = 1'b1;
    repeat (LAT) tick();
    pop();
    chk("sim_ack", 32'(per_ack), 32'd1);
    chk("sim_count", 32'(per_count), 32'd2);
    chk("sim_head", 32'(per_rd_dados), 32'h2);
    per_send = 1'b0;
    wait_ack(1'b0, "sim_fall");
    pop();
    chk("sim_head2", 32'(per_rd_dados), 32'h3);
    pop();
    pop();
    chk("empty_rd_count", 32'(per_count), 32'd0);
    chk("empty_rd_empty", 32'(per_empty), 32'd1);

    // Total counter wrap.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      send_word(4'(i));
      pop();
    end
    chk("wrap_total", 32'(per_total), 32'd4);

    // Reset in the middle of a handshake; the still-high send is taken again.
    per_dados = 4'h7;
    per_send  = 1'b1;
    wait_ack(1'b1, "mid_ack");
    per_rst = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(per_ack), 32'd0);
    chk("mid_rst_empty", 32'(per_empty), 32'd1);
    chk("mid_rst_total", 32'(per_total), 32'd0);
    tick();
    per_rst = 1'b0;
    repeat (LAT) tick();
    chk("dup_ack_early", 32'(per_ack), 32'd0);
    tick();
    chk("dup_ack", 32'(per_ack), 32'd1);
    chk("dup_head", 32'(per_rd_dados), 32'h7);
    per_send = 1'b0;
    wait_ack(1'b0, "dup_fall");

    // Randomized traffic obeying the 4-phase protocol.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!per_send && !per_ack) begin
        per_dados = 4'($urandom);
        if ($urandom_range(0, 2) == 0) per_send = 1'b1;
      end else if (per_send && per_ack && $urandom_range(0, 1) == 0) begin
        per_send = 1'b0;
      end
      per_rd = ($urandom_range(0, 3) == 0);
      tick();
    end
    per_send = 1'b0;
    per_rd   = 1'b0;
    repeat (LAT + 3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
